alu_seq: RTL and testbench
==========================

# alu_seq

Sequential ALU execution unit that consumes the 4-bit ALU control code produced by `aluctrl` and performs the operation on two XLEN operands. It sits in the execute stage behind a valid/ready handshake on both sides. The handshake lets shifts run iteratively, one bit per cycle, while all other operations complete in one cycle. Result and zero flag are registered and held until the downstream stage accepts them.

## Interface
Parameters:
- `XLEN`, 32: operand/result width; power of two, ≥ 8.

Ports:
- `i_clk`  in  1  clock; all logic rising-edge.
- `i_rst`  in  1  reset; synchronous, active-high.
- `i_valid`  in  1  upstream has an operation.
- `o_ready`  out  1  unit can accept an operation this cycle.
- `i_aluctrl`  in  4  op code `{funct7[5], funct3}` as emitted by `aluctrl`.
- `i_op_a`  in  XLEN  operand A (shift source).
- `i_op_b`  in  XLEN  operand B; shift amount = `i_op_b[$clog2(XLEN)-1:0]`.
- `o_valid`  out  1  result available.
- `i_ready`  in  1  downstream accepts the result.
- `o_result`  out  XLEN  registered result.
- `o_zero`  out  1  registered (`o_result == 0`).
- `o_illegal`  out  1  registered; the op code was unsupported.

## Operation
- Op codes:
  - 0000 ADD; 1000 SUB.
  - 0001 SLL; 0101 SRL; 1101 SRA.
  - 0010 SLT (signed); 0011 SLTU.
  - 0100 XOR; 0110 OR; 0111 AND.
- Any other code: result 0, `o_illegal`=1, latency 1. Not an error stall.
- Arithmetic is modulo 2^XLEN; overflow is ignored. SLT/SLTU produce a 0/1 result, zero-extended.
- Accept occurs when `i_valid && o_ready`. Operands and op are captured at accept and ignored afterwards.
- FSM states:
  - IDLE → DONE on accept of a non-shift op, or a shift with amount 0.
  - IDLE → SHIFT on accept of a shift with amount n>0. Load the working register with A and the counter with n.
  - SHIFT: each cycle shift the working register 1 bit (SLL: 0 fill; SRL: 0 fill; SRA: sign fill) and decrement the counter. When the counter reaches 1, → DONE.
  - DONE: `o_valid`=1. If `i_ready`: a simultaneous accept follows the IDLE rules; with no new accept → IDLE. If not `i_ready`: stay, with all outputs held stable.
- `o_ready` = (state==IDLE) || (state==DONE && i_ready). The unit never accepts in SHIFT.
- `o_zero` and `o_illegal` update together with `o_result`.

## Timing
- Reset values: state IDLE; `o_valid`=0, `o_result`=0, `o_zero`=0, `o_illegal`=0. `o_ready`=1 in the first cycle after reset.
- Accept in cycle T:
  - Non-shift op, or shift by 0: `o_valid` at T+1.
  - Shift by n (iterative build): `o_valid` at T+1+n.
  - Worst case: T+XLEN.
- Back-to-back throughput: 1 op/cycle for non-shift ops, because DONE accepts while retiring.
- Reset asserted mid-SHIFT or in DONE discards the operation. Next cycle: IDLE, `o_valid`=0, `o_result`=0.
- `i_valid` asserted while `o_ready`=0 has no effect; upstream must hold it.

## Configuration
- `ALU_SEQ_BARREL_SHIFT_EN`:
  - Defined: shifts use a combinational barrel shifter. All ops, including shifts, take IDLE→DONE with latency 1. The SHIFT state and counter are not built.
  - Undefined (default): iterative shifter as described above. Latency is 1+n for shifts.

## Test plan
- Reset, then ADD A=0x0000_0005, B=0xFFFF_FFFB, `i_ready`=1 → `o_valid` at T+1, `o_result`=0, `o_zero`=1, `o_illegal`=0.
- SRA A=0x8000_0000, B=4 (iterative) → `o_ready`=0 for cycles T+1..T+4; `o_valid` at T+5 with `o_result`=0xF800_0000. With the macro defined, the same op gives the result at T+1.
- SLT A=0xFFFF_FFFF, B=1 → 1. SLTU with the same operands → 0. SUB 3−5 → 0xFFFF_FFFE.
- DONE with `i_ready`=0 for 3 cycles, then `i_ready`=1 together with a new AND 0xF0F0 & 0x0FF0 → the first result is held unchanged for 3 cycles; the new result 0x00F0 appears on the next cycle.
- Op code 1111 → `o_result`=0, `o_illegal`=1, `o_zero`=1. Then assert reset mid-SLL by 20 → next cycle `o_valid`=0, `o_ready`=1, `o_result`=0.

Source files
------------

// File: rtl/alu_seq.sv
// alu_seq: handshaked sequential ALU; iterative 1-bit/cycle shifter unless ALU_SEQ_BARREL_SHIFT_EN selects a barrel shifter
module alu_seq #(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [3:0]      i_aluctrl,
  input  logic [XLEN-1:0] i_op_a,
  input  logic [XLEN-1:0] i_op_b,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_result,
  output logic            o_zero,
  output logic            o_illegal
);
  localparam int SW = $clog2(XLEN);
  typedef enum logic [1:0] {IDLE, DONE, SHIFT} state_t;
  state_t state_q, state_d;
  logic [XLEN-1:0] res_q, res_d, alu;
  logic zero_q, zero_d, ill_q, ill_d, legal, accept;
  logic [SW-1:0] sh;
  assign sh = i_op_b[SW-1:0];
`ifndef ALU_SEQ_BARREL_SHIFT_EN
  logic [SW-1:0] cnt_q, cnt_d;
  logic left_q, left_d, arith_q, arith_d, is_shift;
  assign is_shift = i_aluctrl inside {4'b0001, 4'b0101, 4'b1101};
`endif
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      res_q   <= '0;
      zero_q  <= 1'b0;
      ill_q   <= 1'b0;
`ifndef ALU_SEQ_BARREL_SHIFT_EN
      cnt_q   <= '0;
      left_q  <= 1'b0;
      arith_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      ill_q   <= ill_d;
`ifndef ALU_SEQ_BARREL_SHIFT_EN
      cnt_q   <= cnt_d;
      left_q  <= left_d;
      arith_q <= arith_d;
`endif
    end
  end
  always_comb begin
    alu   = '0;
    legal = 1'b1;
    case (i_aluctrl)
      4'b0000: alu = i_op_a + i_op_b;
      4'b1000: alu = i_op_a - i_op_b;
      4'b0010: alu = {{(XLEN-1){1'b0}}, $signed(i_op_a) < $signed(i_op_b)};
      4'b0011: alu = {{(XLEN-1){1'b0}}, i_op_a < i_op_b};
      4'b0100: alu = i_op_a ^ i_op_b;
      4'b0110: alu = i_op_a | i_op_b;
      4'b0111: alu = i_op_a & i_op_b;
`ifdef ALU_SEQ_BARREL_SHIFT_EN
      4'b0001: alu = i_op_a << sh;
      4'b0101: alu = i_op_a >> sh;
      4'b1101: alu = $unsigned($signed(i_op_a) >>> sh);
`else
      // only shift-by-zero completes here; nonzero shifts go through SHIFT
      4'b0001, 4'b0101, 4'b1101: alu = i_op_a;
`endif
      default: legal = 1'b0;
    endcase
  end
  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    zero_d  = zero_q;
    ill_d   = ill_q;
`ifndef ALU_SEQ_BARREL_SHIFT_EN
    cnt_d   = cnt_q;
    left_d  = left_q;
    arith_d = arith_q;
`endif
    if (accept) begin
      state_d = DONE;
      res_d   = alu;
      zero_d  = alu == '0;
      ill_d   = ~legal;
`ifndef ALU_SEQ_BARREL_SHIFT_EN
      if (is_shift && sh != '0) begin
        state_d = SHIFT;
        res_d   = i_op_a;
        cnt_d   = sh;
        left_d  = ~i_aluctrl[2];
        arith_d = i_aluctrl[3];
      end
`endif
    end else if (state_q == DONE && i_ready) begin
      state_d = IDLE;
`ifndef ALU_SEQ_BARREL_SHIFT_EN
    end else if (state_q == SHIFT) begin
      res_d   = left_q ? res_q << 1 : {arith_q & res_q[XLEN-1], res_q[XLEN-1:1]};
      cnt_d   = cnt_q - 1'b1;
      state_d = cnt_q == 1 ? DONE : SHIFT;
      zero_d  = res_d == '0;
      ill_d   = 1'b0;
`endif
    end
  end
  always_comb begin
    o_valid   = state_q == DONE;
    o_ready   = state_q == IDLE || (state_q == DONE && i_ready);
    accept    = i_valid && o_ready;
    o_result  = res_q;
    o_zero    = zero_q;
    o_illegal = ill_q;
  end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: randomized self-checking bench for alu_seq against a behavioural model
module tb_alu_seq;
  logic        i_clk = 1'b0, i_rst = 1'b1, i_valid = 1'b0, i_ready = 1'b1;
  logic [3:0]  i_aluctrl = '0;
  logic [31:0] i_op_a = '0, i_op_b = '0;
  logic        o_ready, o_valid, o_zero, o_illegal;
  logic [31:0] o_result;
  int errors = 0, checks = 0;

  alu_seq #(.XLEN(32)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_aluctrl(i_aluctrl), .i_op_a(i_op_a), .i_op_b(i_op_b), .o_valid(o_valid),
    .i_ready(i_ready), .o_result(o_result), .o_zero(o_zero), .o_illegal(o_illegal)
  );

  always #5 i_clk = ~i_clk;

  // {illegal, result}
  function automatic logic [32:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int n;
    logic [63:0] ext;
    n = int'(b % 32);
    ext = {{32{a[31]}}, a} >> n;
    case (op)
      4'd0:  return {1'b0, a + b};
      4'd8:  return {1'b0, a - b};
      4'd1:  return {1'b0, a << n};
      4'd5:  return {1'b0, a >> n};
      4'd13: return {1'b0, ext[31:0]};
      4'd2:  return {1'b0, 31'd0, $signed(a) < $signed(b)};
      4'd3:  return {1'b0, 31'd0, a < b};
      4'd4:  return {1'b0, a ^ b};
      4'd6:  return {1'b0, a | b};
      4'd7:  return {1'b0, a & b};
      default: return {1'b1, 32'd0};
    endcase
  endfunction

  function automatic int exp_lat(input logic [3:0] op, input logic [31:0] b);
`ifdef ALU_SEQ_BARREL_SHIFT_EN
    return 1;
`else
    return (op == 4'd1 || op == 4'd5 || op == 4'd13) ? 1 + int'(b % 32) : 1;
`endif
  endfunction

  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [32:0] e;
    int lat;
    e = model(op, a, b);
    i_valid = 1'b1; i_aluctrl = op; i_op_a = a; i_op_b = b; i_ready = 1'b1;
    #1;
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL accept_ready op=%h got=%b want=1", op, o_ready); end
    @(posedge i_clk); @(negedge i_clk);
    i_valid = 1'b0; i_op_a = $urandom; i_op_b = $urandom; i_aluctrl = 4'($urandom);
    lat = 1;
    while (!o_valid && lat < 40) begin
      checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL busy_ready op=%h cyc=%0d got=%b want=0", op, lat, o_ready); end
      @(negedge i_clk); lat++;
    end
    checks++; if (lat != exp_lat(op, b)) begin errors++; $display("FAIL latency op=%h b=%h got=%0d want=%0d", op, b, lat, exp_lat(op, b)); end
    checks++; if (o_result !== e[31:0]) begin errors++; $display("FAIL result op=%h a=%h b=%h got=%h want=%h", op, a, b, o_result, e[31:0]); end
    checks++; if (o_zero !== (e[31:0] == 0)) begin errors++; $display("FAIL zero op=%h got=%b want=%b", op, o_zero, e[31:0] == 0); end
    checks++; if (o_illegal !== e[32]) begin errors++; $display("FAIL illegal op=%h got=%b want=%b", op, o_illegal, e[32]); end
  endtask

  task automatic test_reset;
    i_rst = 1'b1;
    repeat (2) @(negedge i_clk);
    i_rst = 1'b0;
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b want=0", o_valid); end
    checks++; if (o_result !== 32'd0) begin errors++; $display("FAIL reset_result got=%h want=0", o_result); end
    checks++; if (o_zero !== 1'b0 || o_illegal !== 1'b0) begin errors++; $display("FAIL reset_flags got=%b%b want=00", o_zero, o_illegal); end
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b want=1", o_ready); end
  endtask

  task automatic test_directed;
    run_op(4'd0, 32'h0000_0005, 32'hFFFF_FFFB);
    run_op(4'd13, 32'h8000_0000, 32'd4);
    run_op(4'd2, 32'hFFFF_FFFF, 32'd1);
    run_op(4'd3, 32'hFFFF_FFFF, 32'd1);
    run_op(4'd8, 32'd3, 32'd5);
    run_op(4'd15, 32'h1234_5678, 32'h9);
    run_op(4'd1, 32'h0000_0001, 32'd31);
    run_op(4'd5, 32'hDEAD_BEEF, 32'hFFFF_FFE0);
    run_op(4'd13, 32'h8765_4321, 32'd31);
  endtask

  task automatic test_random;
    for (int k = 0; k < 60; k++)
      run_op(4'($urandom_range(0, 15)), $urandom, (k % 3 == 0) ? $urandom_range(0, 40) : $urandom);
  endtask

  task automatic test_hold;
    logic [32:0] e;
    logic [31:0] a, b;
    @(negedge i_clk);
    a = $urandom; b = $urandom;
    e = model(4'd4, a, b);
    i_valid = 1'b1; i_aluctrl = 4'd4; i_op_a = a; i_op_b = b; i_ready = 1'b0;
    @(posedge i_clk); @(negedge i_clk);
    i_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++; if (o_valid !== 1'b1 || o_result !== e[31:0]) begin errors++; $display("FAIL hold k=%0d got=%b/%h want=1/%h", k, o_valid, o_result, e[31:0]); end
      checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL hold_ready k=%0d got=%b want=0", k, o_ready); end
      if (k < 3) @(negedge i_clk);
    end
    i_ready = 1'b1; i_valid = 1'b1; i_aluctrl = 4'd7; i_op_a = 32'hF0F0; i_op_b = 32'h0FF0;
    #1;
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL release_ready got=%b want=1", o_ready); end
    @(posedge i_clk); @(negedge i_clk);
    i_valid = 1'b0;
    checks++; if (o_valid !== 1'b1 || o_result !== 32'h0000_00F0) begin errors++; $display("FAIL hold_next got=%b/%h want=1/000000f0", o_valid, o_result); end
    @(negedge i_clk);
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL hold_idle got=%b want=0", o_valid); end
  endtask

  task automatic test_back_to_back;
    logic [3:0] ops [8] = '{4'd0, 4'd8, 4'd2, 4'd3, 4'd4, 4'd6, 4'd7, 4'd11};
    logic [32:0] e;
    i_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      i_valid = 1'b1; i_aluctrl = ops[$urandom_range(0, 7)]; i_op_a = $urandom; i_op_b = $urandom;
      e = model(i_aluctrl, i_op_a, i_op_b);
      #1;
      checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready k=%0d got=%b want=1", k, o_ready); end
      @(posedge i_clk); @(negedge i_clk);
      checks++; if (o_valid !== 1'b1 || {o_illegal, o_result} !== e) begin errors++; $display("FAIL b2b k=%0d got=%b/%b/%h want=1/%b/%h", k, o_valid, o_illegal, o_result, e[32], e[31:0]); end
    end
    i_valid = 1'b0;
    @(negedge i_clk);
  endtask

  task automatic test_reset_mid_shift;
    i_valid = 1'b1; i_aluctrl = 4'd1; i_op_a = 32'h0000_0ABC; i_op_b = 32'd20; i_ready = 1'b1;
    @(posedge i_clk); @(negedge i_clk);
    i_valid = 1'b0;
    repeat (5) @(negedge i_clk);
    i_rst = 1'b1;
    @(posedge i_clk); @(negedge i_clk);
    i_rst = 1'b0;
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got=%b want=0", o_valid); end
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready got=%b want=1", o_ready); end
    checks++; if (o_result !== 32'd0) begin errors++; $display("FAIL midrst_result got=%h want=0", o_result); end
    repeat (25) @(negedge i_clk);
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL midrst_stale got=%b want=0", o_valid); end
  endtask

  initial begin
    @(negedge i_clk);
    test_reset;
    test_directed;
    test_random;
    test_hold;
    test_back_to_back;
    test_reset_mid_shift;
    run_op(4'd6, 32'h1, 32'h2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
